// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 access encodings,
// the FSM state type and the memory word width in bytes.
package lsu_pkg;

    localparam int unsigned WORD_BYTES = 4;

    // Access-size encodings carried on req_funct3
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RMW_RD = 3'd2,
        WRITE  = 3'd3,
        RESP   = 3'd4
    } state_t;

    // True when funct3 names a supported access for the given direction
    function automatic logic funct3_legal(input logic we, input logic [2:0] funct3);
        if (we)
            return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        else
            return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                   (funct3 == F3_BU) || (funct3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte/halfword extraction with sign/zero extension for
// loads, and low-byte merge for sub-word stores (read-modify-write).
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] rd,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    // Select the load result and build the store merge word
    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        load_data  = rd;
        merge_data = wdata;
        case (funct3)
            F3_B:    load_data = {{24{rd[7]}}, rd[7:0]};
            F3_H:    load_data = {{16{rd[15]}}, rd[15:0]};
            F3_BU:   load_data = {24'b0, rd[7:0]};
            F3_HU:   load_data = {16'b0, rd[15:0]};
            default: load_data = rd;
        endcase
        case (funct3)
            F3_B:    merge_data = {rd[31:8], wdata[7:0]};
            F3_H:    merge_data = {rd[31:16], wdata[15:0]};
            default: merge_data = wdata;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one access at a time, runs it through a small
// FSM against a byte-addressed, word-wide memory and returns a one-cycle
// response. Sub-word stores use a read-modify-write of the full word.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned halfword/word
// accesses are rejected instead of being performed natively.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned DEPTH_BYTES = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        memwrite,
    output logic [31:0] addr,
    output logic [31:0] wd,
    input  logic [31:0] rd
);

    localparam logic [31:0] LAST_ADDR = 32'(DEPTH_BYTES - WORD_BYTES);

    state_t      state, next_state;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [31:0] wdata_q;
    logic        accept;
    logic        req_err;
    logic        misalign;
    logic [31:0] load_data;
    logic [31:0] merge_data;

    assign req_ready = (state == IDLE) && !reset;
    assign accept    = req_valid && req_ready;
    assign memwrite  = (state == WRITE) && !reset;

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    // Every access must fit a whole word inside the memory, even byte ones,
    // because the memory port always reads and writes four bytes.
    assign req_err = !funct3_legal(req_we, req_funct3) || (req_addr > LAST_ADDR) || misalign;

    lsu_align u_align (
        .funct3     (funct3_q),
        .rd         (rd),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    // Next-state decode; rejected accesses skip straight to RESP
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err)                  next_state = RESP;
                    else if (!req_we)             next_state = LOAD;
                    else if (req_funct3 == F3_W)  next_state = WRITE;
                    else                          next_state = RMW_RD;
                end
            end
            LOAD:    next_state = RESP;
            RMW_RD:  next_state = WRITE;
            WRITE:   next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State, request capture and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            addr       <= '0;
            wd         <= '0;
            we_q       <= 1'b0;
            funct3_q   <= '0;
            wdata_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            state      <= next_state;
            resp_valid <= (next_state == RESP);
            case (state)
                IDLE: begin
                    if (accept) begin
                        we_q       <= req_we;
                        funct3_q   <= req_funct3;
                        wdata_q    <= req_wdata;
                        addr       <= req_addr;
                        resp_err   <= req_err;
                        resp_rdata <= '0;
                        if (req_we && (req_funct3 == F3_W))
                            wd <= req_wdata;
                    end
                end
                LOAD:    resp_rdata <= load_data;
                RMW_RD:  wd <= merge_data;
                RESP:    addr <= '0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: byte-array memory attached to the memory
// port, directed cases followed by randomized accesses compared against a
// byte-level reference model. Honours LSU_MISALIGN_TRAP_EN when defined.
module tb_lsu;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;

    int checks = 0;
    int errors = 0;

    // Memory seen by the DUT and the model's own copy
    logic [7:0] mem     [DEPTH];
    logic [7:0] ref_mem [DEPTH];

    // Last observed response, for directed constant checks
    logic [31:0] last_rdata;
    logic        last_err;

    lsu #(.DEPTH_BYTES(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .memwrite   (memwrite),
        .addr       (addr),
        .wd         (wd),
        .rd         (rd)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        if (a < 32'(DEPTH)) return mem[a[7:0]];
        return 8'h00;
    endfunction

    assign rd = {mem_byte(addr + 3), mem_byte(addr + 2), mem_byte(addr + 1), mem_byte(addr)};

    // Memory write port: four bytes at addr..addr+3
    always @(posedge clk) begin
        if (memwrite) begin
            for (int i = 0; i < 4; i++)
                if (addr + 32'(i) < 32'(DEPTH)) mem[addr[7:0] + 8'(i)] <= wd[8*i +: 8];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_word(input logic [31:0] a);
        return {ref_mem[a[7:0] + 8'd3], ref_mem[a[7:0] + 8'd2], ref_mem[a[7:0] + 8'd1], ref_mem[a[7:0]]};
    endfunction

    function automatic logic model_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
        logic bad;
        if (we) bad = !(f3 inside {3'b000, 3'b001, 3'b010});
        else    bad = !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        if (a > 32'(DEPTH - 4)) bad = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
        if ((f3 == 3'b001 || f3 == 3'b101) && a[0]) bad = 1'b1;
        if (f3 == 3'b010 && a[1:0] != 2'b00) bad = 1'b1;
`endif
        return bad;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] w;
        w = ref_word(a);
        case (f3)
            3'b000:  return {{24{w[7]}}, w[7:0]};
            3'b001:  return {{16{w[15]}}, w[15:0]};
            3'b100:  return {24'h0, w[7:0]};
            3'b101:  return {16'h0, w[15:0]};
            default: return w;
        endcase
    endfunction

    // Whole word that memory should hold after the store
    function automatic logic [31:0] model_store(input logic [2:0] f3, input logic [31:0] a,
                                                input logic [31:0] wdata);
        logic [31:0] w;
        int n;
        w = ref_word(a);
        n = 1 << f3[1:0];
        for (int i = 0; i < n; i++) w[8*i +: 8] = wdata[8*i +: 8];
        return w;
    endfunction

    task automatic poke(input logic [31:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            mem[a[7:0] + 8'(i)]     = w[8*i +: 8];
            ref_mem[a[7:0] + 8'(i)] = w[8*i +: 8];
        end
    endtask

    // One access: drive, follow to the response, compare with the model
    task automatic run(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wdata);
        logic        e_err;
        logic [31:0] e_rdata;
        logic [31:0] e_wd;
        int          e_lat;
        int          e_writes;
        int          cyc;
        int          writes;
        int          wcyc;
        logic [31:0] seen_wd;
        logic [31:0] seen_waddr;
        logic        got;

        e_err    = model_err(we, f3, a);
        e_rdata  = (!e_err && !we) ? model_load(f3, a) : 32'h0;
        e_wd     = (!e_err && we) ? model_store(f3, a, wdata) : 32'h0;
        e_writes = (!e_err && we) ? 1 : 0;
        e_lat    = (!e_err && we && f3 != 3'b010) ? 3 : 2;

        @(negedge clk);
        check({tag, "_ready"}, {31'h0, req_ready}, 32'h1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wdata;
        @(posedge clk);
        #1;
        // Garbage after accept must be ignored
        req_valid  = 1'b0;
        req_we     = $urandom_range(0, 1);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;

        cyc = 0; writes = 0; wcyc = 0; got = 1'b0;
        seen_wd = '0; seen_waddr = '0;
        while (!got && cyc < 8) begin
            @(negedge clk);
            cyc++;
            if (memwrite) begin
                writes++;
                wcyc       = cyc;
                seen_wd    = wd;
                seen_waddr = addr;
            end
            if (resp_valid) begin
                got        = 1'b1;
                last_rdata = resp_rdata;
                last_err   = resp_err;
            end else begin
                check({tag, "_busy_ready"}, {31'h0, req_ready}, 32'h0);
            end
        end
        check({tag, "_resp"}, {31'h0, got}, 32'h1);
        if (got) begin
            check({tag, "_err"}, {31'h0, last_err}, {31'h0, e_err});
            check({tag, "_rdata"}, last_rdata, e_rdata);
            if (e_err) check({tag, "_err_lat"}, {31'h0, (cyc <= 2)}, 32'h1);
            else       check({tag, "_lat"}, cyc, e_lat);
        end
        check({tag, "_writes"}, writes, e_writes);
        if (e_writes == 1 && writes == 1) begin
            check({tag, "_wd"}, seen_wd, e_wd);
            check({tag, "_waddr"}, seen_waddr, a);
            check({tag, "_wcyc"}, wcyc, e_lat - 1);
            for (int i = 0; i < 4; i++) ref_mem[a[7:0] + 8'(i)] = e_wd[8*i +: 8];
        end
        // One response pulse only
        @(negedge clk);
        check({tag, "_pulse"}, {31'h0, resp_valid}, 32'h0);
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = '0;
        req_addr   = '0;
        req_wdata  = '0;
        last_rdata = '0;
        last_err   = 1'b0;
        // NOTE: the memory is a plain array filled by the bench, not reset by hardware.
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready",  {31'h0, req_ready},  32'h0);
        check("rst_valid",  {31'h0, resp_valid}, 32'h0);
        check("rst_rdata",  resp_rdata,          32'h0);
        check("rst_err",    {31'h0, resp_err},   32'h0);
        check("rst_addr",   addr,                32'h0);
        check("rst_wd",     wd,                  32'h0);
        check("rst_mwrite", {31'h0, memwrite},   32'h0);
        reset = 1'b0;
        #1;
        check("rst_release_ready", {31'h0, req_ready}, 32'h1);

        // Loads of a known word
        poke(32'h10, 32'h8899AABB);
        run("lb",  1'b0, 3'b000, 32'h10, 32'h0); check("lb_const",  last_rdata, 32'hFFFFFFBB);
        run("lbu", 1'b0, 3'b100, 32'h10, 32'h0); check("lbu_const", last_rdata, 32'h000000BB);
        run("lh",  1'b0, 3'b001, 32'h10, 32'h0); check("lh_const",  last_rdata, 32'hFFFFAABB);
        run("lw",  1'b0, 3'b010, 32'h10, 32'h0); check("lw_const",  last_rdata, 32'h8899AABB);

        // Byte store with read-modify-write, then read back
        poke(32'h20, 32'h11223344);
        run("sb", 1'b1, 3'b000, 32'h20, 32'hDEADBEEF);
        run("sb_lw", 1'b0, 3'b010, 32'h20, 32'h0);
        check("sb_lw_const", last_rdata, 32'h112233EF);

        // Word store
        run("sw", 1'b1, 3'b010, 32'h30, 32'hCAFEF00D);
        check("sw_rdata_const", last_rdata, 32'h0);
        run("sw_lw", 1'b0, 3'b010, 32'h30, 32'h0);
        check("sw_lw_const", last_rdata, 32'hCAFEF00D);

        // Range and funct3 errors
        run("lw_range", 1'b0, 3'b010, 32'hFD, 32'h0);
        check("lw_range_const", {31'h0, last_err}, 32'h1);
        run("ld_f3", 1'b0, 3'b011, 32'h10, 32'h0);
        check("ld_f3_const", {31'h0, last_err}, 32'h1);
        run("sw_range_hi", 1'b1, 3'b010, 32'h8000_0000, 32'h12345678);
        run("lw_edge", 1'b0, 3'b010, 32'hFC, 32'h0);

        // Misaligned halfword
        poke(32'h40, 32'h44332211);
        run("lh_mis", 1'b0, 3'b001, 32'h41, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        check("lh_mis_const", {31'h0, last_err}, 32'h1);
`else
        check("lh_mis_const", last_rdata, 32'h00003322);
`endif

        // Reset during RMW_RD of a halfword store: nothing must happen
        poke(32'h50, 32'h55667788);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b001;
        req_addr   = 32'h50;
        req_wdata  = 32'hA5A5A5A5;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_ready_in_reset", {31'h0, req_ready}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_mwrite", {31'h0, memwrite},   32'h0);
            check("abort_valid",  {31'h0, resp_valid}, 32'h0);
        end
        reset = 1'b0;
        @(negedge clk);
        check("abort_ready_after", {31'h0, req_ready}, 32'h1);
        check("abort_mem", {mem[8'h53], mem[8'h52], mem[8'h51], mem[8'h50]}, 32'h55667788);

        // Randomized accesses
        for (int n = 0; n < 300; n++) begin
            logic        we;
            logic [2:0]  f3;
            logic [31:0] a;
            we = $urandom_range(0, 1);
            f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
            if (!we && $urandom_range(0, 3) == 0) f3 = {1'b1, 1'b0, 1'($urandom)};
            a  = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, DEPTH - 1));
            run("rnd", we, f3, a, $urandom);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        // Whole-memory comparison
        for (int i = 0; i < DEPTH; i += 4)
            check("final_mem", {mem[i + 3], mem[i + 2], mem[i + 1], mem[i]},
                  {ref_mem[i + 3], ref_mem[i + 2], ref_mem[i + 1], ref_mem[i]});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
